// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: loads I-MEM from a UART byte stream (16-bit word-count header, little-endian words)
module boot_loader_ctrl #(
    parameter int BITS   = 32,
    parameter int ADDRIW = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [BITS-1:0]   wdata_data,
    output logic [ADDRIW-1:0] wdata_addr,
    output logic              we_boot,
    output logic              bootloading,
    output logic              cpu_rst_n,
    output logic              boot_done,
    output logic              boot_err
);
    typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, LOAD, DONE} state_t;

    localparam logic [16:0] DEPTH = 17'(1) << ADDRIW;

    state_t      state, state_nx;
    logic [15:0] count, idx;
    logic [1:0]  bidx;
    logic [23:0] asm_lo;
    logic        word_done, in_range, last_word;

    assign word_done = state == LOAD && rx_valid && bidx == 2'd3;
    assign in_range  = {1'b0, idx} < DEPTH;
    assign last_word = idx + 16'd1 == count;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state: header bytes, then words until the index reaches the count
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (boot_start) state_nx = HDR_LO;
            HDR_LO:  if (rx_valid) state_nx = HDR_HI;
            HDR_HI:  if (rx_valid) state_nx = ({rx_data, count[7:0]} == 16'd0) ? DONE : LOAD;
            LOAD:    if (word_done && last_word) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // datapath and registered outputs; status outputs follow the upcoming state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            idx         <= '0;
            bidx        <= '0;
            asm_lo      <= '0;
            wdata_data  <= '0;
            wdata_addr  <= '0;
            we_boot     <= 1'b0;
            bootloading <= 1'b0;
            cpu_rst_n   <= 1'b0;
            boot_done   <= 1'b0;
            boot_err    <= 1'b0;
        end else begin
            we_boot     <= word_done && in_range;
            boot_done   <= state_nx == DONE;
            bootloading <= state_nx != IDLE;
            cpu_rst_n   <= state_nx == IDLE;
            if (state == IDLE && boot_start) begin
                boot_err <= 1'b0;
                idx      <= '0;
                bidx     <= '0;
                count    <= '0;
            end
            if (state == HDR_LO && rx_valid) count[7:0] <= rx_data;
            if (state == HDR_HI && rx_valid) count[15:8] <= rx_data;
            if (state == LOAD && rx_valid) begin
                bidx <= bidx + 2'd1;
                if (bidx != 2'd3) asm_lo <= {rx_data, asm_lo[23:8]};
                else begin
                    idx <= idx + 16'd1;
                    if (in_range) begin
                        wdata_data <= {rx_data, asm_lo};
                        wdata_addr <= idx[ADDRIW-1:0];
                    end else begin
                        boot_err <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb_boot_loader_ctrl: scoreboard bench for boot_loader_ctrl with a word-level reference model
module tb_boot_loader_ctrl;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          boot_start = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic [31:0]   wdata_data;
    logic [AW-1:0] wdata_addr;
    logic          we_boot, bootloading, cpu_rst_n, boot_done, boot_err;

    typedef struct packed { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic err; logic coinc; } done_t;

    wr_t        wq[$];
    done_t      dq[$];
    logic [7:0] fixed_bytes[$];
    int         checks = 0, failures = 0, done_cnt = 0;

    boot_loader_ctrl #(.BITS(32), .ADDRIW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .boot_start(boot_start), .rx_data(rx_data), .rx_valid(rx_valid),
        .wdata_data(wdata_data), .wdata_addr(wdata_addr), .we_boot(we_boot),
        .bootloading(bootloading), .cpu_rst_n(cpu_rst_n), .boot_done(boot_done), .boot_err(boot_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every write and every done pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (we_boot) begin
            if (wq.size() == 0) chk("unexp_write", 32'(we_boot), 32'd0);
            else begin
                wr_t e;
                e = wq.pop_front();
                chk("wr_addr", 32'(wdata_addr), 32'(e.addr));
                chk("wr_data", wdata_data, e.data);
            end
        end
        if (boot_done) begin
            done_cnt++;
            if (dq.size() == 0) chk("unexp_done", 32'(boot_done), 32'd0);
            else begin
                done_t d;
                d = dq.pop_front();
                chk("done_err", 32'(boot_err), 32'(d.err));
                chk("done_last_wr", 32'(we_boot), 32'(d.coinc));
                chk("done_pending_wr", 32'(wq.size()), 32'd0);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic start_boot();
        boot_start = 1'b1;
        @(posedge clk); #2;
        boot_start = 1'b0;
        chk("start_bootloading", 32'(bootloading), 32'd1);
        chk("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("start_err_clear", 32'(boot_err), 32'd0);
    endtask

    // reference model: word i = bytes 4i..4i+3 little-endian, written only if i fits in I-MEM
    task automatic do_load(input int n, input int max_gap, input bit mid_start);
        logic [7:0]  b[$];
        logic [31:0] w;
        int          d0;
        b = fixed_bytes;
        fixed_bytes = {};
        if (b.size() == 0) for (int i = 0; i < 4 * n; i++) b.push_back(8'($urandom));
        for (int i = 0; i < n; i++) begin
            w = 32'(b[4*i]) + (32'(b[4*i+1]) << 8) + (32'(b[4*i+2]) << 16) + (32'(b[4*i+3]) << 24);
            if (i < DEPTH) wq.push_back('{addr: AW'(i), data: w});
        end
        dq.push_back('{err: n > DEPTH, coinc: n > 0 && n <= DEPTH});
        d0 = done_cnt;
        start_boot();
        send_byte(n[7:0], $urandom_range(max_gap, 0));
        send_byte(n[15:8], $urandom_range(max_gap, 0));
        for (int i = 0; i < 4 * n; i++) begin
            if (mid_start && i == 5) boot_start = 1'b1;
            send_byte(b[i], $urandom_range(max_gap, 0));
            boot_start = 1'b0;
        end
        for (int k = 0; k < 12 && done_cnt == d0; k++) begin @(posedge clk); #2; end
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
        chk("release_bootloading", 32'(bootloading), 32'd0);
        chk("release_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("idle_err", 32'(boot_err), 32'(n > DEPTH));
    endtask

    initial begin
        repeat (3) begin @(posedge clk); #2; end
        chk("rst_data", wdata_data, 32'd0);
        chk("rst_addr", 32'(wdata_addr), 32'd0);
        chk("rst_ctrl", {27'd0, we_boot, bootloading, cpu_rst_n, boot_done, boot_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_cpu_low", 32'(cpu_rst_n), 32'd0);
        @(posedge clk); #2;
        chk("rst_release_cpu_high", 32'(cpu_rst_n), 32'd1);
        chk("rst_release_bl", 32'(bootloading), 32'd0);

        fixed_bytes = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_load(2, 0, 1'b0);
        do_load(0, 2, 1'b0);
        do_load(5, 1, 1'b0);
        do_load(1, 0, 1'b0);
        do_load(2, 0, 1'b1);

        // reset in the middle of the second word: only word 0 may be written
        wq.push_back('{addr: AW'(0), data: 32'hA1B2C3D4});
        start_boot();
        send_byte(8'd2, 0);
        send_byte(8'd0, 0);
        send_byte(8'hD4, 0);
        send_byte(8'hC3, 1);
        send_byte(8'hB2, 0);
        send_byte(8'hA1, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk("abort_ctrl", {27'd0, we_boot, bootloading, cpu_rst_n, boot_done, boot_err}, 32'd0);
        chk("abort_data", wdata_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #2; end
        chk("abort_idle_bl", 32'(bootloading), 32'd0);
        chk("abort_pending_wr", 32'(wq.size()), 32'd0);
        do_load(3, 0, 1'b0);

        for (int t = 0; t < 20; t++) do_load($urandom_range(6, 0), $urandom_range(2, 0), 1'($urandom_range(1, 0)));

        repeat (3) @(posedge clk);
        #2;
        chk("end_wq_empty", 32'(wq.size()), 32'd0);
        chk("end_dq_empty", 32'(dq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
